// File: rtl/local_mem_resp_pkg.sv
// Shared types and constants for the local-memory burst responder.
// Optional stall injection is enabled with LOCAL_MEM_RESP_STALL_EN.
package local_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_ISSUE,
        RD_DRAIN
    } state_t;

    localparam int unsigned MAX_BURST = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          ERR_W     = 8;

    function automatic logic burst_ok(input int unsigned n);
        return (n >= 1) && (n <= MAX_BURST);
    endfunction

endpackage

// File: rtl/local_mem_resp_ram.sv
// Simple dual-port byte-enable RAM with a fixed-latency read pipe.
// Stall injection (LOCAL_MEM_RESP_STALL_EN) lives in the top, not here.
module local_mem_resp_ram
    import local_mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [READ_LATENCY-1:0] rd_vld
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dq  [READ_LATENCY];
    logic [READ_LATENCY-1:0] vq;

    // Array and data pipe carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            dq[0] <= mem[raddr];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            dq[i] <= dq[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq <= '0;
        end else begin
            vq[0] <= re;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vq[i] <= vq[i-1];
            end
        end
    end

    assign rd_data = dq[READ_LATENCY-1];
    assign rd_vld  = vq;

endmodule

// File: rtl/local_mem_burst_responder.sv
// Avalon-MM burst responder emulating one DDR4 bank in on-chip RAM.
// Define LOCAL_MEM_RESP_STALL_EN for LFSR-driven waitrequest injection.
module local_mem_burst_responder
    import local_mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 10,
    parameter int BURST_WIDTH  = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                    primary_clk,
    input  logic                    reset_n,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    input  logic [BURST_WIDTH-1:0]  burstcount,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    write,
    input  logic                    read,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    output logic [7:0]              err_count,
    output logic                    busy
);

    localparam logic [READ_LATENCY-1:0] LAST_ONLY =
        READ_LATENCY'(1) << (READ_LATENCY - 1);

    state_t                  state_q;
    logic                    ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BURST_WIDTH-1:0]  cnt_q;
    logic [ERR_W-1:0]        err_q;

    logic                    stall;
    logic                    accept;
    logic                    in_idle;
    logic                    in_wr;
    logic                    in_rd;
    logic                    bc_ok;
    logic                    bc_one;
    logic                    cnt_last;
    logic                    wr_go;
    logic                    rd_go;
    logic                    wr_beat;
    logic                    err_inc;
    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [ADDR_WIDTH-1:0]   ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_dout;
    logic [READ_LATENCY-1:0] rd_vld;
    logic                    last_beat;

    assign in_idle  = (state_q == IDLE);
    assign in_wr    = (state_q == WR_BURST);
    assign in_rd    = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
    assign bc_ok    = burst_ok(32'(burstcount));
    assign bc_one   = (burstcount == BURST_WIDTH'(1));
    assign cnt_last = (cnt_q == BURST_WIDTH'(1));

`ifdef LOCAL_MEM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge primary_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00) && (in_idle || in_wr);
`else
    assign stall = 1'b0;
`endif

    assign waitrequest = !ready_q || in_rd || stall;
    assign accept      = !waitrequest;

    // A simultaneous read+write in IDLE keeps the write.
    assign wr_go   = accept && in_idle && write && bc_ok;
    assign rd_go   = accept && in_idle && read && !write && bc_ok;
    assign wr_beat = accept && in_wr && write;
    assign err_inc = accept && (
                       (in_idle && (read || write) && !bc_ok) ||
                       (in_idle && read && write && bc_ok) ||
                       (in_wr && read));

    assign ram_we    = wr_go || wr_beat;
    assign ram_waddr = wr_go ? address : addr_q;
    assign ram_re    = rd_go || (state_q == RD_ISSUE);
    assign ram_raddr = rd_go ? address : addr_q;

    assign last_beat = (rd_vld == LAST_ONLY);

    always_ff @(posedge primary_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            ready_q <= 1'b1;
            if (err_inc && (err_q != '1)) begin
                err_q <= err_q + ERR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (wr_go || rd_go) begin
                        addr_q <= address + ADDR_WIDTH'(1);
                        cnt_q  <= burstcount - BURST_WIDTH'(1);
                    end
                    if (wr_go && !bc_one) begin
                        state_q <= WR_BURST;
                    end else if (rd_go) begin
                        state_q <= bc_one ? RD_DRAIN : RD_ISSUE;
                    end
                end
                WR_BURST: begin
                    if (wr_beat) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        cnt_q  <= cnt_q - BURST_WIDTH'(1);
                        if (cnt_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                RD_ISSUE: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    cnt_q  <= cnt_q - BURST_WIDTH'(1);
                    if (cnt_last) begin
                        state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (last_beat) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    local_mem_resp_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_ram (
        .clk    (primary_clk),
        .rst_n  (reset_n),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (writedata),
        .be     (byteenable),
        .re     (ram_re),
        .raddr  (ram_raddr),
        .rd_data(ram_dout),
        .rd_vld (rd_vld)
    );

    assign readdatavalid = rd_vld[READ_LATENCY-1];
    assign readdata      = ram_dout & {DATA_WIDTH{readdatavalid}};
    assign err_count     = err_q;
    assign busy          = !in_idle || (|rd_vld);

endmodule

// File: tb/tb_local_mem_burst_responder.sv
// Directed bench for local_mem_burst_responder (default build,
// LOCAL_MEM_RESP_STALL_EN undefined).
module tb_local_mem_burst_responder;

    localparam int DW = 512;
    localparam int AW = 10;
    localparam int BW = 3;
    localparam int BE = DW / 8;

    logic          primary_clk = 1'b0;
    logic          reset_n     = 1'b0;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic [BW-1:0] burstcount = '0;
    logic [DW-1:0] writedata  = '0;
    logic [AW-1:0] address    = '0;
    logic          write      = 1'b0;
    logic          read       = 1'b0;
    logic [BE-1:0] byteenable = '0;
    logic [7:0]    err_count;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] exp_d [4];
    logic [DW-1:0] be_exp;

    always #5 primary_clk = ~primary_clk;

    local_mem_burst_responder dut (
        .primary_clk  (primary_clk),
        .reset_n      (reset_n),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .burstcount   (burstcount),
        .writedata    (writedata),
        .address      (address),
        .write        (write),
        .read         (read),
        .byteenable   (byteenable),
        .err_count    (err_count),
        .busy         (busy)
    );

    task automatic chk(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge primary_clk);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (waitrequest !== 1'b0 && t < 50) begin
            cyc();
            t++;
        end
        chk("ready", DW'(waitrequest), DW'(1'b0));
    endtask

    task automatic do_reset(input int n);
        cyc();
        reset_n = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        #1;
        chk("rst_wreq", DW'(waitrequest), DW'(1'b1));
        chk("rst_rdv", DW'(readdatavalid), DW'(1'b0));
        chk("rst_rdata", readdata, '0);
        chk("rst_err", DW'(err_count), DW'(8'd0));
        chk("rst_busy", DW'(busy), DW'(1'b0));
        repeat (n - 1) cyc();
        cyc();
        reset_n = 1'b1;
        chk("rel_wreq_hi", DW'(waitrequest), DW'(1'b1));
        cyc();
        chk("rel_wreq_lo", DW'(waitrequest), DW'(1'b0));
    endtask

    // Beat k carries d0+k; leaves write high on the final beat.
    task automatic do_write(input logic [AW-1:0] a, input int n,
                            input logic [DW-1:0] d0,
                            input logic [BE-1:0] be);
        cyc();
        read  = 1'b0;
        write = 1'b0;
        wait_ready();
        write      = 1'b1;
        address    = a;
        burstcount = BW'(n);
        byteenable = be;
        writedata  = d0;
        for (int k = 1; k < n; k++) begin
            cyc();
            writedata = d0 + DW'(k);
            address   = ~a;
        end
    endtask

    task automatic rd_burst(input logic [AW-1:0] a, input int n);
        cyc();
        write = 1'b0;
        read  = 1'b0;
        wait_ready();
        read       = 1'b1;
        address    = a;
        burstcount = BW'(n);
        cyc();
        read    = 1'b0;
        address = ~a;
        chk("rd_gap", DW'(readdatavalid), DW'(1'b0));
        chk("rd_wreq", DW'(waitrequest), DW'(1'b1));
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("rd_vld", DW'(readdatavalid), DW'(1'b1));
            chk("rd_data", readdata, exp_d[i]);
        end
        chk("rd_wreq_last", DW'(waitrequest), DW'(1'b1));
        cyc();
        chk("rd_end_vld", DW'(readdatavalid), DW'(1'b0));
        chk("rd_end_wreq", DW'(waitrequest), DW'(1'b0));
        chk("rd_end_busy", DW'(busy), DW'(1'b0));
    endtask

    initial begin
        do_reset(3);

        // Burst 4 write then read, back to back.
        do_write(10'h010, 4, DW'(32'hA0), '1);
        for (int i = 0; i < 4; i++) exp_d[i] = DW'(32'hA0 + i);
        rd_burst(10'h010, 4);

        // Wrap at the top of memory.
        do_write(10'h3FF, 2, DW'(32'hB0), '1);
        exp_d[0] = DW'(32'hB1);
        rd_burst(10'h000, 1);
        exp_d[0] = DW'(32'hB0);
        exp_d[1] = DW'(32'hB1);
        rd_burst(10'h3FF, 2);

        // Byte-enable merge.
        do_write(10'h020, 1, '1, '1);
        do_write(10'h020, 1, '0, BE'(1));
        be_exp = '1;
        be_exp[7:0] = 8'h00;
        exp_d[0] = be_exp;
        rd_burst(10'h020, 1);

        // Write burst with an idle gap between beats.
        cyc();
        write = 1'b1; address = 10'h070; burstcount = 3'd2;
        writedata = DW'(32'hF0); byteenable = '1;
        cyc();
        write = 1'b0;
        cyc();
        write = 1'b1; writedata = DW'(32'hF1); address = 10'h3AA;
        exp_d[0] = DW'(32'hF0);
        exp_d[1] = DW'(32'hF1);
        rd_burst(10'h070, 2);

        // Illegal burstcount 0 read.
        cyc();
        read = 1'b1; burstcount = 3'd0; address = 10'h040;
        cyc();
        read = 1'b0; burstcount = 3'd1;
        chk("err_bc0", DW'(err_count), DW'(8'd1));
        chk("bc0_wreq", DW'(waitrequest), DW'(1'b0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bc0_no_rdv", DW'(readdatavalid), DW'(1'b0));
        end

        // Read and write together: write wins.
        read = 1'b1; write = 1'b1; burstcount = 3'd1;
        address = 10'h030; writedata = DW'(32'hC5); byteenable = '1;
        cyc();
        read = 1'b0; write = 1'b0;
        chk("err_rw", DW'(err_count), DW'(8'd2));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rw_no_rdv", DW'(readdatavalid), DW'(1'b0));
        end
        exp_d[0] = DW'(32'hC5);
        rd_burst(10'h030, 1);

        // Read during a write burst is ignored.
        do_write(10'h050, 2, DW'(32'hE0), '1);
        read = 1'b1;
        cyc();
        read = 1'b0; write = 1'b0;
        chk("err_rd_in_wr", DW'(err_count), DW'(8'd3));
        chk("rd_in_wr_rdv", DW'(readdatavalid), DW'(1'b0));
        exp_d[0] = DW'(32'hE0);
        exp_d[1] = DW'(32'hE1);
        rd_burst(10'h050, 2);

        // Burstcount above the maximum.
        cyc();
        read = 1'b1; burstcount = 3'd5; address = 10'h010;
        cyc();
        read = 1'b0;
        chk("err_bc5", DW'(err_count), DW'(8'd4));
        chk("bc5_busy", DW'(busy), DW'(1'b0));

        // Reset while a burst-4 read is issuing.
        cyc();
        wait_ready();
        read = 1'b1; address = 10'h010; burstcount = 3'd4;
        cyc();
        read = 1'b0;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_rdv", DW'(readdatavalid), DW'(1'b0));
            cyc();
        end
        for (int i = 0; i < 4; i++) exp_d[i] = DW'(32'hA0 + i);
        rd_burst(10'h010, 4);

        // Reset mid write burst keeps committed beats.
        cyc();
        wait_ready();
        write = 1'b1; address = 10'h060; burstcount = 3'd4;
        writedata = DW'(32'hD0); byteenable = '1;
        cyc();
        writedata = DW'(32'hD1);
        do_reset(2);
        exp_d[0] = DW'(32'hD0);
        exp_d[1] = DW'(32'hD1);
        rd_burst(10'h060, 2);

        // Error counter saturates.
        cyc();
        read = 1'b1; burstcount = 3'd0;
        repeat (260) cyc();
        read = 1'b0;
        cyc();
        chk("err_sat", DW'(err_count), DW'(8'd255));
        do_reset(1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

endmodule
